// File: rtl/mmio_router_pkg.sv
// Shared types and constants for the MMIO router family.
// State encodings, counter width and the default error read-data pattern.
package mmio_router_pkg;

  localparam int          MMIO_RT_CNT_W     = 16;
  localparam logic [31:0] MMIO_RT_ERR_RDATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    MMIO_RT_IDLE = 2'd0,
    MMIO_RT_BUSY = 2'd1,
    MMIO_RT_RESP = 2'd2
  } mmio_rt_state_e;

  // Width of an encoded target index; a single target still needs one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mmio_router_if.sv
// CPU-side and target-side bus of the MMIO router.
// The router takes the slave view; a CPU/target model takes the master view.
interface mmio_router_if #(
  parameter int XLEN  = 32,
  parameter int N_TGT = 4
);
  logic                       cpu_mem_req;
  logic                       cpu_mem_we;
  logic [XLEN-1:0]            cpu_mem_addr;
  logic [XLEN-1:0]            cpu_mem_wdata;
  logic [XLEN-1:0]            cpu_mem_rdata;
  logic                       cpu_mem_ready;
  logic                       cpu_mem_err;
  logic [N_TGT-1:0]           tgt_req;
  logic                       tgt_we;
  logic [XLEN-1:0]            tgt_addr;
  logic [XLEN-1:0]            tgt_wdata;
  logic [N_TGT-1:0][XLEN-1:0] tgt_rdata;
  logic [N_TGT-1:0]           tgt_ready;

  modport slave (
    input  cpu_mem_req, cpu_mem_we, cpu_mem_addr, cpu_mem_wdata, tgt_rdata, tgt_ready,
    output cpu_mem_rdata, cpu_mem_ready, cpu_mem_err, tgt_req, tgt_we, tgt_addr, tgt_wdata
  );

  modport master (
    output cpu_mem_req, cpu_mem_we, cpu_mem_addr, cpu_mem_wdata, tgt_rdata, tgt_ready,
    input  cpu_mem_rdata, cpu_mem_ready, cpu_mem_err, tgt_req, tgt_we, tgt_addr, tgt_wdata
  );
endinterface

// File: rtl/mmio_addr_match.sv
// Combinational base/mask window matcher; lowest matching index wins.
// Shared with the IO-path routers, so it carries no router state.
module mmio_addr_match
  import mmio_router_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int N     = 4,
  parameter int IDX_W = idx_w(N)
) (
  input  logic [XLEN-1:0]   addr,
  input  logic [N*XLEN-1:0] base,
  input  logic [N*XLEN-1:0] mask,
  output logic              hit,
  output logic [IDX_W-1:0]  idx
);
  logic [N-1:0] win_hit;

  for (genvar i = 0; i < N; i++) begin : g_win
    assign win_hit[i] = (addr & mask[i*XLEN +: XLEN]) == base[i*XLEN +: XLEN];
  end

  // Scan high to low so the lowest matching window is the last write.
  always_comb begin
    hit = |win_hit;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (win_hit[i]) idx = IDX_W'(i);
    end
  end
endmodule

// File: rtl/mmio_router.sv
// N-target MMIO router: registered decode, one-hot target request, timeout/unmapped errors.
// Optional per-target hit and error counters are built when MMIO_ROUTER_STATS_EN is defined.
module mmio_router
  import mmio_router_pkg::*;
#(
  parameter int                    XLEN      = 32,
  parameter int                    N_TGT     = 4,
  parameter logic [N_TGT*XLEN-1:0] TGT_BASE  = '0,
  parameter logic [N_TGT*XLEN-1:0] TGT_MASK  = '0,
  parameter int                    TIMEOUT   = 255,
  parameter logic [XLEN-1:0]       ERR_RDATA = XLEN'(MMIO_RT_ERR_RDATA)
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  mmio_router_if.slave                          bus,
  output logic [N_TGT-1:0][MMIO_RT_CNT_W-1:0]   stat_hit_cnt,
  output logic [MMIO_RT_CNT_W-1:0]              stat_err_cnt
);
  localparam int                     IDX_W = idx_w(N_TGT);
  localparam int                     CNT_W = MMIO_RT_CNT_W;
  localparam logic [CNT_W-1:0]       TMO   = CNT_W'(TIMEOUT);

  mmio_rt_state_e   state_q, state_d;
  logic [N_TGT-1:0] tgt_req_q, tgt_req_d;
  logic             tgt_we_q, tgt_we_d;
  logic [XLEN-1:0]  addr_q, addr_d;
  logic [XLEN-1:0]  wdata_q, wdata_d;
  logic [IDX_W-1:0] sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  rdata_q, rdata_d;
  logic             ready_q, ready_d;
  logic             err_q, err_d;
  logic             hit;
  logic [IDX_W-1:0] idx;

  mmio_addr_match #(.XLEN(XLEN), .N(N_TGT), .IDX_W(IDX_W)) u_match (
    .addr (bus.cpu_mem_addr),
    .base (TGT_BASE),
    .mask (TGT_MASK),
    .hit  (hit),
    .idx  (idx)
  );

  always_comb begin
    state_d   = state_q;
    tgt_req_d = tgt_req_q;
    tgt_we_d  = tgt_we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    sel_d     = sel_q;
    cnt_d     = cnt_q;
    rdata_d   = '0;
    ready_d   = 1'b0;
    err_d     = 1'b0;
    unique case (state_q)
      MMIO_RT_IDLE: if (bus.cpu_mem_req) begin
        tgt_we_d = bus.cpu_mem_we;
        addr_d   = bus.cpu_mem_addr;
        wdata_d  = bus.cpu_mem_wdata;
        sel_d    = idx;
        cnt_d    = CNT_W'(1);
        if (hit) begin
          state_d        = MMIO_RT_BUSY;
          tgt_req_d      = '0;
          tgt_req_d[idx] = 1'b1;
        end else begin
          state_d = MMIO_RT_RESP;
          ready_d = 1'b1;
          err_d   = 1'b1;
          rdata_d = ERR_RDATA;
        end
      end
      // cnt_q counts BUSY cycles from 1; ready on the last allowed cycle still wins.
      MMIO_RT_BUSY: begin
        if (bus.tgt_ready[sel_q]) begin
          state_d   = MMIO_RT_RESP;
          tgt_req_d = '0;
          ready_d   = 1'b1;
          rdata_d   = tgt_we_q ? '0 : bus.tgt_rdata[sel_q];
        end else if (cnt_q == TMO) begin
          state_d   = MMIO_RT_RESP;
          tgt_req_d = '0;
          ready_d   = 1'b1;
          err_d     = 1'b1;
          rdata_d   = ERR_RDATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      MMIO_RT_RESP: state_d = MMIO_RT_IDLE;
      default:      state_d = MMIO_RT_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= MMIO_RT_IDLE;
      tgt_req_q <= '0;
      tgt_we_q  <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      sel_q     <= '0;
      cnt_q     <= '0;
      rdata_q   <= '0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tgt_req_q <= tgt_req_d;
      tgt_we_q  <= tgt_we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      sel_q     <= sel_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
      ready_q   <= ready_d;
      err_q     <= err_d;
    end
  end

  assign bus.tgt_req       = tgt_req_q;
  assign bus.tgt_we        = tgt_we_q;
  assign bus.tgt_addr      = addr_q;
  assign bus.tgt_wdata     = wdata_q;
  assign bus.cpu_mem_rdata = rdata_q;
  assign bus.cpu_mem_ready = ready_q;
  assign bus.cpu_mem_err   = err_q;

`ifdef MMIO_ROUTER_STATS_EN
  logic [N_TGT-1:0][CNT_W-1:0] hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]            err_cnt_q, err_cnt_d;

  // Counted in the RESP cycle; sel_q stays latched until the next accept.
  always_comb begin
    hit_cnt_d = hit_cnt_q;
    err_cnt_d = err_cnt_q;
    if (ready_q && err_q && err_cnt_q != '1)
      err_cnt_d = err_cnt_q + 1'b1;
    if (ready_q && !err_q && hit_cnt_q[sel_q] != '1)
      hit_cnt_d[sel_q] = hit_cnt_q[sel_q] + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      hit_cnt_q <= hit_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign stat_hit_cnt = hit_cnt_q;
  assign stat_err_cnt = err_cnt_q;
`else
  assign stat_hit_cnt = '0;
  assign stat_err_cnt = '0;
`endif
endmodule

// File: tb/tb_mmio_router.sv
// Randomized scoreboard bench for mmio_router: 4 targets with an overlapping window, TIMEOUT=4.
// A target model answers after a chosen number of BUSY cycles; a monitor checks every response.
module tb_mmio_router;
  localparam int NT  = 4;
  localparam int TMO = 4;
  localparam logic [31:0] ERRV = 32'hDEAD_BEEF;

  logic clk, rst_n;
  logic [NT-1:0][15:0] stat_hit_cnt;
  logic [15:0]         stat_err_cnt;

  mmio_router_if #(.XLEN(32), .N_TGT(NT)) bus ();

  mmio_router #(
    .XLEN     (32),
    .N_TGT    (NT),
    .TGT_BASE ({32'h2000_0000, 32'h4000_0000, 32'h0000_0000, 32'h4000_0000}),
    .TGT_MASK ({32'hE000_0000, 32'hF000_0000, 32'hF000_0000, 32'hFFFF_F000}),
    .TIMEOUT  (TMO),
    .ERR_RDATA(ERRV)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .stat_hit_cnt (stat_hit_cnt),
    .stat_err_cnt (stat_err_cnt)
  );

  // Reference windows, index 0 highest priority.
  logic [31:0] mbase [NT] = '{32'h4000_0000, 32'h0000_0000, 32'h4000_0000, 32'h2000_0000};
  logic [31:0] mmask [NT] = '{32'hFFFF_F000, 32'hF000_0000, 32'hF000_0000, 32'hE000_0000};

  typedef struct {
    int          sel;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          busy;
    int          c0;
  } exp_t;

  exp_t q[$];
  int   checks = 0, errors = 0;
  int   cyc = 0;
  int   cur_sel = -1, cur_dly = 0;
  int   hit_m [NT];
  int   err_m = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic int model_sel(input logic [31:0] a);
    for (int i = 0; i < NT; i++)
      if ((a & mmask[i]) == mbase[i]) return i;
    return -1;
  endfunction

  // Expected response from the decode rules; d is the BUSY cycle on which the target answers.
  function automatic exp_t mk_exp(input logic [31:0] a, input logic w, input logic [31:0] wd, input int d);
    exp_t e;
    e.sel = model_sel(a); e.we = w; e.addr = a; e.wdata = wd; e.c0 = 0;
    if (e.sel < 0) begin
      e.err = 1'b1; e.rdata = ERRV; e.lat = 2; e.busy = 0;
    end else if (d <= TMO) begin
      e.err = 1'b0; e.rdata = w ? 32'h0 : bus.tgt_rdata[e.sel]; e.lat = d + 2; e.busy = d;
    end else begin
      e.err = 1'b1; e.rdata = ERRV; e.lat = TMO + 2; e.busy = TMO;
    end
    return e;
  endfunction

  task automatic do_txn(input logic [31:0] a, input logic w, input logic [31:0] wd, input int d);
    exp_t e;
    int   to;
    for (int i = 0; i < NT; i++) bus.tgt_rdata[i] = $urandom;
    e = mk_exp(a, w, wd, d);
    e.c0 = cyc;
    q.push_back(e);
    cur_sel = e.sel; cur_dly = d;
    bus.cpu_mem_req = 1'b1; bus.cpu_mem_we = w; bus.cpu_mem_addr = a; bus.cpu_mem_wdata = wd;
    to = 0;
    do begin
      @(negedge clk);
      to++;
    end while (!bus.cpu_mem_ready && to < 40);
    if (!bus.cpu_mem_ready) begin
      checks++; errors++;
      $display("FAIL txn_no_ready addr=%h waited=%0d cycles", a, to);
      q.delete();
    end
    bus.cpu_mem_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_stats();
    repeat (2) @(negedge clk);
    for (int i = 0; i < NT; i++) begin
`ifdef MMIO_ROUTER_STATS_EN
      chk($sformatf("stat_hit_cnt[%0d]", i), 64'(stat_hit_cnt[i]), 64'(hit_m[i]));
`else
      chk($sformatf("stat_hit_cnt[%0d]", i), 64'(stat_hit_cnt[i]), 64'(0));
`endif
    end
`ifdef MMIO_ROUTER_STATS_EN
    chk("stat_err_cnt", 64'(stat_err_cnt), 64'(err_m));
`else
    chk("stat_err_cnt", 64'(stat_err_cnt), 64'(0));
`endif
  endtask

  initial begin
    exp_t        e;
    logic [31:0] a;
    int          r, d;
    rst_n = 1'b0;
    bus.cpu_mem_req = 1'b0; bus.cpu_mem_we = 1'b0;
    bus.cpu_mem_addr = '0; bus.cpu_mem_wdata = '0;
    bus.tgt_ready = '0; bus.tgt_rdata = '0;
    foreach (hit_m[i]) hit_m[i] = 0;
    #12;
    chk("rst_tgt_req",   64'(bus.tgt_req), 64'(0));
    chk("rst_tgt_we",    64'(bus.tgt_we), 64'(0));
    chk("rst_tgt_addr",  64'(bus.tgt_addr), 64'(0));
    chk("rst_tgt_wdata", 64'(bus.tgt_wdata), 64'(0));
    chk("rst_ready",     64'(bus.cpu_mem_ready), 64'(0));
    chk("rst_err",       64'(bus.cpu_mem_err), 64'(0));
    chk("rst_rdata",     64'(bus.cpu_mem_rdata), 64'(0));
    chk("rst_stat_err",  64'(stat_err_cnt), 64'(0));

    fork
      begin : target_model
        logic [NT-1:0] rv;
        int bcnt;
        bcnt = 0;
        forever begin
          @(negedge clk);
          if (bus.tgt_req != '0) bcnt++; else bcnt = 0;
          rv = NT'($urandom);
          if (cur_sel >= 0) rv[cur_sel] = (bcnt == cur_dly);
          bus.tgt_ready = rv;
        end
      end
      begin : monitor
        exp_t m;
        int   bz;
        bz = 0;
        forever begin
          @(negedge clk);
          if (!rst_n) bz = 0;
          else begin
            if (bus.tgt_req != '0) begin
              bz++;
              if (q.size() == 0) chk("tgt_req_unexpected", 64'(bus.tgt_req), 64'(0));
              else begin
                m = q[0];
                chk("tgt_req_onehot", 64'(bus.tgt_req), (m.sel >= 0) ? (64'(1) << m.sel) : 64'(0));
                if (m.sel >= 0) begin
                  chk("tgt_we",    64'(bus.tgt_we), 64'(m.we));
                  chk("tgt_addr",  64'(bus.tgt_addr), 64'(m.addr));
                  chk("tgt_wdata", 64'(bus.tgt_wdata), 64'(m.wdata));
                end
              end
            end
            if (!bus.cpu_mem_ready) begin
              chk("rdata_when_idle", 64'(bus.cpu_mem_rdata), 64'(0));
            end else if (q.size() == 0) begin
              chk("ready_unexpected", 64'(bus.cpu_mem_ready), 64'(0));
            end else begin
              m = q.pop_front();
              chk($sformatf("rdata@%h", m.addr), 64'(bus.cpu_mem_rdata), 64'(m.rdata));
              chk($sformatf("err@%h", m.addr), 64'(bus.cpu_mem_err), 64'(m.err));
              chk($sformatf("latency@%h", m.addr), 64'(cyc - m.c0 + 1), 64'(m.lat));
              chk($sformatf("req_cycles@%h", m.addr), 64'(bz), 64'(m.busy));
              if (m.err) err_m++; else hit_m[m.sel]++;
              bz = 0;
            end
          end
        end
      end
      begin : watchdog
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
      end
    join_none

    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed: decode, write, unmapped, timeout boundaries, priority.
    do_txn(32'h4000_0010, 1'b0, 32'h0,         1);
    do_txn(32'h0000_0100, 1'b1, 32'hA5A5_A5A5, 1);
    do_txn(32'h8000_0000, 1'b0, 32'h0,         1);
    do_txn(32'h0000_0200, 1'b0, 32'h0,         TMO);
    do_txn(32'h0000_0300, 1'b0, 32'h0,         TMO + 1);
    do_txn(32'h2000_0040, 1'b1, 32'hCAFE_F00D, 99);
    do_txn(32'h4123_4560, 1'b0, 32'h0,         2);
    do_txn(32'h4000_0FFC, 1'b0, 32'h0,         3);
    do_txn(32'h1000_0000, 1'b1, 32'h1,         1);
    do_txn(32'h0000_0400, 1'b0, 32'h0,         1);
    do_txn(32'h0000_0500, 1'b1, 32'h5,         2);
    check_stats();

    // Reset in the middle of BUSY aborts without a response.
    for (int i = 0; i < NT; i++) bus.tgt_rdata[i] = $urandom;
    e = mk_exp(32'h0000_2000, 1'b1, 32'h1357_9BDF, 99);
    e.c0 = cyc;
    q.push_back(e);
    cur_sel = e.sel; cur_dly = 99;
    bus.cpu_mem_req = 1'b1; bus.cpu_mem_we = 1'b1;
    bus.cpu_mem_addr = 32'h0000_2000; bus.cpu_mem_wdata = 32'h1357_9BDF;
    repeat (3) @(negedge clk);
    bus.cpu_mem_req = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("abort_tgt_req",   64'(bus.tgt_req), 64'(0));
    chk("abort_tgt_we",    64'(bus.tgt_we), 64'(0));
    chk("abort_tgt_addr",  64'(bus.tgt_addr), 64'(0));
    chk("abort_tgt_wdata", 64'(bus.tgt_wdata), 64'(0));
    chk("abort_ready",     64'(bus.cpu_mem_ready), 64'(0));
    q.delete();
    foreach (hit_m[i]) hit_m[i] = 0;
    err_m = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    do_txn(32'h0000_2000, 1'b0, 32'h0, 1);

    // Random traffic over mapped, overlapping and unmapped regions.
    for (int n = 0; n < 150; n++) begin
      a = $urandom;
      r = $urandom_range(0, 3);
      if (r == 0) a = {20'h40000, a[11:0]};
      d = $urandom_range(1, TMO + 2);
      do_txn(a, 1'($urandom), $urandom, d);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    check_stats();
    repeat (3) @(negedge clk);
    chk("queue_drained", 64'(q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
